// File: rtl/ddr_axis_pkg.sv
// Shared types and widths for the DDR <-> AXI4-Stream data movers.
package ddr_axis_pkg;

    localparam int DATA_W = 512;
    localparam int KEEP_W = 64;
    localparam int MON_W  = 16;

    // One buffered write beat: payload plus its AXIS byte enables.
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [KEEP_W-1:0] keep;
    } wr_beat_t;

    // DDR masks use 1 = "do not write", the inverse of AXIS TKEEP.
    function automatic logic [KEEP_W-1:0] keep_to_mask(input logic [KEEP_W-1:0] keep);
        return ~keep;
    endfunction

endpackage

// File: rtl/axi4_write_data_if.sv
// AXI4-Stream slave bundle carrying write data from the DMA MM2S channel.
interface axi4_write_data_if;
    import ddr_axis_pkg::*;

    logic [DATA_W-1:0] S_AXIS_TDATA;
    logic [KEEP_W-1:0] S_AXIS_TKEEP;
    logic              S_AXIS_TVALID;
    logic              S_AXIS_TLAST;
    logic              S_AXIS_TREADY;

    modport master (
        output S_AXIS_TDATA, S_AXIS_TKEEP, S_AXIS_TVALID, S_AXIS_TLAST,
        input  S_AXIS_TREADY
    );

    modport slave (
        input  S_AXIS_TDATA, S_AXIS_TKEEP, S_AXIS_TVALID, S_AXIS_TLAST,
        output S_AXIS_TREADY
    );

endinterface

// File: rtl/axis_wr_fifo.sv
// Simple-dual-port beat FIFO with a registered read port. The storage array
// has no reset so it maps onto block/ultra RAM; the level is a separate
// counter so full and empty never alias when the pointers meet.
module axis_wr_fifo
    import ddr_axis_pkg::*;
#(
    parameter int FIFO_DEPTH = 512
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  wr_beat_t                      wr_beat,
    input  logic                          pop,
    output wr_beat_t                      rd_beat,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic [$clog2(FIFO_DEPTH):0]   level_next
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    wr_beat_t         mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level_q;

    assign level = level_q;
    assign empty = (level_q == '0);

    // Next level: a simultaneous push and pop cancel out.
    always_comb begin
        level_next = level_q;
        case ({push, pop})
            2'b10:   level_next = level_q + 1'b1;
            2'b01:   level_next = level_q - 1'b1;
            default: level_next = level_q;
        endcase
    end

    // RAM write port.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_beat;
        end
    end

    // Registered RAM read port; holds its value between pops.
    always_ff @(posedge clk) begin
        if (pop) begin
            rd_beat <= mem[rd_ptr];
        end
    end

    // Pointers wrap naturally at the power-of-two depth; level tracks occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            level_q <= level_next;
        end
    end

endmodule

// File: rtl/axi4_write_data.sv
// AXI4-Stream to DDR write-data streamer. Buffers DMA beats and answers each
// DDR data request one cycle later. A request against an empty FIFO cannot be
// stalled, so it is answered with a fully masked zero beat and flagged sticky.
// Optional build macro: AXI4_WRITE_DATA_STATS_EN enables the beat/packet
// counters; without it both counter outputs are tied to zero.
module axi4_write_data
    import ddr_axis_pkg::*;
#(
    parameter int FIFO_DEPTH  = 512,
    parameter int BURST_BEATS = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    axi4_write_data_if.slave              s_axis,
    input  logic                          ddr_wr_req,
    output logic [DATA_W-1:0]             ddr_wr_data,
    output logic [KEEP_W-1:0]             ddr_wr_mask,
    output logic                          ddr_wr_data_valid,
    output logic                          burst_ready,
    output logic [$clog2(FIFO_DEPTH):0]   wr_data_count,
    input  logic                          err_clr,
    output logic                          underflow_err,
    output logic [MON_W-1:0]              latest_data_monitor,
    output logic [31:0]                   beat_count,
    output logic [31:0]                   pkt_count
);

    localparam int               LVL_W     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(FIFO_DEPTH);
    localparam logic [LVL_W-1:0] BURST_LVL = LVL_W'(BURST_BEATS);

    logic             tready_q;
    logic             burst_q;
    logic             err_q;
    logic             push_p0;
    logic             pop_p0;
    logic             uf_p0;
    logic             fifo_empty;
    logic             vld_p1;
    logic             hit_p1;
    logic [MON_W-1:0] mon_q;
    wr_beat_t         in_beat_p0;
    wr_beat_t         head_p1;
    logic [LVL_W-1:0] level;
    logic [LVL_W-1:0] level_next;

    // Output data: a real beat passes through, an underflow beat writes nothing.
    function automatic logic [DATA_W-1:0] out_data(input logic hit, input wr_beat_t beat);
        return hit ? beat.data : '0;
    endfunction

    function automatic logic [KEEP_W-1:0] out_mask(input logic hit, input wr_beat_t beat);
        return hit ? keep_to_mask(beat.keep) : '1;
    endfunction

    assign push_p0    = s_axis.S_AXIS_TVALID & tready_q;
    assign pop_p0     = ddr_wr_req & ~fifo_empty;
    assign uf_p0      = ddr_wr_req & fifo_empty;
    assign in_beat_p0 = {s_axis.S_AXIS_TDATA, s_axis.S_AXIS_TKEEP};

    axis_wr_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push_p0),
        .wr_beat    (in_beat_p0),
        .pop        (pop_p0),
        .rd_beat    (head_p1),
        .empty      (fifo_empty),
        .level      (level),
        .level_next (level_next)
    );

    // ---- stage p0 -> p1: request registered alongside the RAM read ----

    // Valid pulse and hit/underflow select for the beat leaving next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            hit_p1 <= 1'b0;
        end else begin
            vld_p1 <= ddr_wr_req;
            if (ddr_wr_req) begin
                hit_p1 <= ~fifo_empty;
            end
        end
    end

    assign ddr_wr_data       = out_data(hit_p1, head_p1);
    assign ddr_wr_mask       = out_mask(hit_p1, head_p1);
    assign ddr_wr_data_valid = vld_p1;

    // Handshake and burst flags registered from the post-update level.
    always_ff @(posedge clk) begin
        if (rst) begin
            tready_q <= 1'b0;
            burst_q  <= 1'b0;
        end else begin
            tready_q <= (level_next < DEPTH_LVL);
            burst_q  <= (level_next >= BURST_LVL);
        end
    end

    assign s_axis.S_AXIS_TREADY = tready_q;
    assign burst_ready          = burst_q;
    assign wr_data_count        = level;

    // Sticky underflow flag; a new underflow wins over a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (uf_p0) begin
            err_q <= 1'b1;
        end else if (err_clr) begin
            err_q <= 1'b0;
        end
    end

    assign underflow_err = err_q;

    // Remember the low half-word of the most recent valid output beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            mon_q <= '0;
        end else if (vld_p1) begin
            mon_q <= ddr_wr_data[MON_W-1:0];
        end
    end

    assign latest_data_monitor = vld_p1 ? ddr_wr_data[MON_W-1:0] : mon_q;

`ifdef AXI4_WRITE_DATA_STATS_EN
    logic [31:0] beat_cnt_q;
    logic [31:0] pkt_cnt_q;

    // Accepted-beat and TLAST counters, free-running with natural wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt_q <= '0;
            pkt_cnt_q  <= '0;
        end else if (push_p0) begin
            beat_cnt_q <= beat_cnt_q + 32'd1;
            if (s_axis.S_AXIS_TLAST) begin
                pkt_cnt_q <= pkt_cnt_q + 32'd1;
            end
        end
    end

    assign beat_count = beat_cnt_q;
    assign pkt_count  = pkt_cnt_q;
`else
    logic unused_tlast;
    assign unused_tlast = s_axis.S_AXIS_TLAST;
    assign beat_count   = '0;
    assign pkt_count    = '0;
`endif

endmodule

// File: tb/tb_axi4_write_data.sv
// Randomized scoreboard bench for axi4_write_data: a queue-based FIFO model
// produces the expected beat for every request and the expected flags for
// every cycle; a monitor compares beats whenever the DUT presents one.
`timescale 1ns/1ps
module tb_axi4_write_data;
    import ddr_axis_pkg::*;

    localparam int FIFO_DEPTH  = 512;
    localparam int BURST_BEATS = 8;
    localparam int LVL_W       = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [KEEP_W-1:0] mask;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              ddr_wr_req;
    logic [DATA_W-1:0] ddr_wr_data;
    logic [KEEP_W-1:0] ddr_wr_mask;
    logic              ddr_wr_data_valid;
    logic              burst_ready;
    logic [LVL_W-1:0]  wr_data_count;
    logic              err_clr;
    logic              underflow_err;
    logic [MON_W-1:0]  latest_data_monitor;
    logic [31:0]       beat_count;
    logic [31:0]       pkt_count;

    axi4_write_data_if bus ();

    axi4_write_data #(
        .FIFO_DEPTH  (FIFO_DEPTH),
        .BURST_BEATS (BURST_BEATS)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .s_axis              (bus),
        .ddr_wr_req          (ddr_wr_req),
        .ddr_wr_data         (ddr_wr_data),
        .ddr_wr_mask         (ddr_wr_mask),
        .ddr_wr_data_valid   (ddr_wr_data_valid),
        .burst_ready         (burst_ready),
        .wr_data_count       (wr_data_count),
        .err_clr             (err_clr),
        .underflow_err       (underflow_err),
        .latest_data_monitor (latest_data_monitor),
        .beat_count          (beat_count),
        .pkt_count           (pkt_count)
    );

    always #5 clk = ~clk;

    int          n_chk   = 0;
    int          n_pass  = 0;
    logic        mon_en  = 1'b0;
    logic        last_hs = 1'b0;

    // Reference model state.
    wr_beat_t    mq[$];
    exp_t        exp_q[$];
    logic        m_rdy;
    logic        m_burst;
    logic        m_err;
    logic [31:0] m_beats;
    logic [31:0] m_pkts;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, want %0h at %0t", nm, act, req, $time);
    endfunction

    function automatic void chkw(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, want %0h at %0t", nm, act, req, $time);
    endfunction

    function automatic logic [DATA_W-1:0] rand_data();
        logic [DATA_W-1:0] d;
        d = '0;
        for (int i = 0; i < DATA_W / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic check_state();
        chk("tready", 64'(bus.S_AXIS_TREADY), 64'(m_rdy));
        chk("wr_data_count", 64'(wr_data_count), 64'(mq.size()));
        chk("burst_ready", 64'(burst_ready), 64'(m_burst));
        chk("underflow_err", 64'(underflow_err), 64'(m_err));
`ifdef AXI4_WRITE_DATA_STATS_EN
        chk("beat_count", 64'(beat_count), 64'(m_beats));
        chk("pkt_count", 64'(pkt_count), 64'(m_pkts));
`else
        chk("beat_count", 64'(beat_count), 64'(0));
        chk("pkt_count", 64'(pkt_count), 64'(0));
`endif
    endtask

    task automatic check_reset_values();
        chkw("rst_ddr_wr_data", ddr_wr_data, '0);
        chk("rst_ddr_wr_mask", 64'(ddr_wr_mask), {64{1'b1}});
        chk("rst_data_valid", 64'(ddr_wr_data_valid), 64'(0));
        chk("rst_latest_monitor", 64'(latest_data_monitor), 64'(0));
        chk("rst_tready", 64'(bus.S_AXIS_TREADY), 64'(0));
        chk("rst_count", 64'(wr_data_count), 64'(0));
        chk("rst_burst", 64'(burst_ready), 64'(0));
        chk("rst_err", 64'(underflow_err), 64'(0));
        chk("rst_beat_count", 64'(beat_count), 64'(0));
        chk("rst_pkt_count", 64'(pkt_count), 64'(0));
    endtask

    // One clock cycle: compare flags, drive inputs, advance the model, wait.
    task automatic cycle(input logic v, input logic [DATA_W-1:0] d, input logic [KEEP_W-1:0] k,
                         input logic l, input logic rq, input logic clr, input logic r);
        logic     acc;
        logic     uf;
        wr_beat_t b;
        check_state();
        last_hs           = v && bus.S_AXIS_TREADY;
        rst               = r;
        bus.S_AXIS_TVALID = v;
        bus.S_AXIS_TDATA  = d;
        bus.S_AXIS_TKEEP  = k;
        bus.S_AXIS_TLAST  = l;
        ddr_wr_req        = rq;
        err_clr           = clr;
        if (r) begin
            mq.delete();
            m_rdy = 1'b0; m_burst = 1'b0; m_err = 1'b0; m_beats = '0; m_pkts = '0;
        end else begin
            acc = v && m_rdy;
            uf  = rq && (mq.size() == 0);
            if (rq) begin
                if (uf) begin
                    exp_q.push_back('{data: '0, mask: '1});
                end else begin
                    b = mq.pop_front();
                    exp_q.push_back('{data: b.data, mask: ~b.keep});
                end
            end
            if (uf) m_err = 1'b1;
            else if (clr) m_err = 1'b0;
            if (acc) begin
                mq.push_back('{data: d, keep: k});
                m_beats = m_beats + 32'd1;
                if (l) m_pkts = m_pkts + 32'd1;
            end
            m_rdy   = (mq.size() < FIFO_DEPTH);
            m_burst = (mq.size() >= BURST_BEATS);
        end
        @(negedge clk);
    endtask

    task automatic idle();
        cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic push(input logic [DATA_W-1:0] d, input logic [KEEP_W-1:0] k, input logic l);
        cycle(1'b1, d, k, l, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic req();
        cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_reset_values();
        idle();
    endtask

    // Monitor: every cycle a beat is due exactly when a request is outstanding.
    initial begin : monitor
        exp_t e;
        wait (mon_en);
        forever begin
            @(posedge clk);
            #1;
            chk("data_valid", 64'(ddr_wr_data_valid), 64'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                if (ddr_wr_data_valid) begin
                    chkw("ddr_wr_data", ddr_wr_data, e.data);
                    chk("ddr_wr_mask", 64'(ddr_wr_mask), 64'(e.mask));
                    chk("latest_data_monitor", 64'(latest_data_monitor), 64'(e.data[MON_W-1:0]));
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: summary not reached after %0d checks", n_chk);
        $fatal(1);
    end

    initial begin : stim
        int hs;
        rst = 1'b1;
        bus.S_AXIS_TVALID = 1'b0;
        bus.S_AXIS_TDATA  = '0;
        bus.S_AXIS_TKEEP  = '0;
        bus.S_AXIS_TLAST  = 1'b0;
        ddr_wr_req = 1'b0;
        err_clr    = 1'b0;
        m_rdy = 1'b0; m_burst = 1'b0; m_err = 1'b0; m_beats = '0; m_pkts = '0;
        @(posedge clk);
        @(negedge clk);
        mon_en = 1'b1;
        check_reset_values();
        idle();

        // Four ordered beats drained by back-to-back requests.
        for (int i = 0; i < 4; i++) push(DATA_W'(8'h11 + i), '1, 1'b0);
        for (int i = 0; i < 4; i++) req();
        idle();

        // Partial byte enables become the inverted DDR mask.
        push(DATA_W'(32'hCAFE_0A5A), 64'h0000_0000_0000_000F, 1'b0);
        req();
        idle();

        // Underflow, clear, and clear colliding with a new underflow.
        req();
        idle();
        cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle();
        cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
        idle();
        cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Push into empty and request in the same cycle: no bypass.
        cycle(1'b1, DATA_W'(32'h77), '1, 1'b0, 1'b1, 1'b0, 1'b0);
        req();
        cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Fill to full with TVALID held, then a single request frees one slot.
        hs = 0;
        for (int i = 0; i < FIFO_DEPTH + 3; i++) begin
            push(rand_data(), {$urandom, $urandom}, 1'b0);
            hs += int'(last_hs);
        end
        chk("fill_accepted", 64'(hs), 64'(FIFO_DEPTH));
        chk("tready_when_full", 64'(bus.S_AXIS_TREADY), 64'(0));
        hs = 0;
        cycle(1'b1, rand_data(), '1, 1'b0, 1'b1, 1'b0, 1'b0);
        hs += int'(last_hs);
        for (int i = 0; i < 3; i++) begin
            push(rand_data(), '1, 1'b0);
            hs += int'(last_hs);
        end
        chk("refill_accepted", 64'(hs), 64'(1));
        for (int i = 0; i < FIFO_DEPTH + 2; i++) req();
        cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Burst threshold: 7 beats, 8th beat, then push+pop at level 8.
        for (int i = 0; i < BURST_BEATS - 1; i++) push(rand_data(), '1, 1'b0);
        idle();
        push(rand_data(), '1, 1'b0);
        idle();
        cycle(1'b1, rand_data(), '1, 1'b0, 1'b1, 1'b0, 1'b0);
        idle();
        for (int i = 0; i < BURST_BEATS; i++) req();
        idle();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            cycle(1'b1 & ($urandom_range(0, 3) != 0), rand_data(), {$urandom, $urandom},
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 9) == 0, 1'b0);
        end
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (mq.size() == 0) break;
            req();
        end
        cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Reset with five beats buffered, then a counted stream.
        for (int i = 0; i < 5; i++) push(rand_data(), '1, 1'b0);
        idle();
        chk("level_before_reset", 64'(wr_data_count), 64'(5));
        do_reset();
        for (int i = 0; i < 10; i++) push(rand_data(), '1, (i == 1) || (i == 4) || (i == 8));
        idle();
`ifdef AXI4_WRITE_DATA_STATS_EN
        chk("final_beat_count", 64'(beat_count), 64'(10));
        chk("final_pkt_count", 64'(pkt_count), 64'(3));
`else
        chk("final_beat_count", 64'(beat_count), 64'(0));
        chk("final_pkt_count", 64'(pkt_count), 64'(0));
`endif
        for (int i = 0; i < 10; i++) req();
        idle();
        idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
